// File: rtl/sdram_write_feeder_pkg.sv
// Shared definitions for the SDRAM write feeder and its FIFO.
// FIFO entries are {mask[3:0], data[31:0]}, mask active-high per byte.
package sdram_write_feeder_pkg;

   typedef logic [1:0] feed_state_t;

   localparam feed_state_t FEED_IDLE  = 2'd0;
   localparam feed_state_t FEED_FILL  = 2'd1;
   localparam feed_state_t FEED_DRAIN = 2'd2;
   localparam feed_state_t FEED_WAIT  = 2'd3;

   localparam int MASK_HI = 35;
   localparam int MASK_LO = 32;
   localparam int DATA_HI = 31;
   localparam int ENTRY_W = 36;

   typedef logic [ENTRY_W-1:0] entry_t;

   // A set byte select means "write this byte", so the SDRAM mask is its inverse.
   function automatic entry_t make_entry(
      input logic [3:0]  sel,
      input logic [31:0] dat
   );
      entry_t e;
      e = '0;
      e[MASK_HI:MASK_LO] = ~sel;
      e[DATA_HI:0] = dat;
      return e;
   endfunction

endpackage

// File: rtl/sdram_write_feeder_if.sv
// Wishbone slave bus carrying write cycles into the feeder.
// The master side drives the request; the slave returns ack.
interface sdram_write_feeder_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;

   modport master (
      output wbs_cyc_i,
      output wbs_stb_i,
      output wbs_we_i,
      output wbs_sel_i,
      output wbs_adr_i,
      output wbs_dat_i,
      input  wbs_ack_o
   );

   modport slave (
      input  wbs_cyc_i,
      input  wbs_stb_i,
      input  wbs_we_i,
      input  wbs_sel_i,
      input  wbs_adr_i,
      input  wbs_dat_i,
      output wbs_ack_o
   );

endinterface

// File: rtl/sdram_write_feeder_fifo.sv
// Synchronous FIFO of mask/data entries with a registered read port.
// Read data only changes on an accepted pop and holds otherwise.
module sdram_sync_fifo
   import sdram_write_feeder_pkg::*;
#(
   parameter int DEPTH_BITS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  entry_t            wr_data,
   input  logic              rd,
   output entry_t            rd_data,
   output logic              full,
   output logic              empty,
   output logic [DEPTH_BITS:0] count
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

   entry_t                mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  push;
   logic                  pop;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign push  = wr && !full;
   assign pop   = rd && !empty;

   // Storage array; contents need no reset since count guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered read word.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_write_feeder.sv
// Wishbone write front end feeding bursts to the SDRAM write stage.
// A burst runs while addresses stay contiguous; a gap closes it.
module sdram_write_feeder
   import sdram_write_feeder_pkg::*;
#(
   parameter int DEPTH_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   sdram_write_feeder_if.slave  wbs,
   output logic                 en,
   output logic [21:0]          address,
   input  logic                 ready,
   output logic [35:0]          fifo_data,
   output logic                 fifo_empty,
   input  logic                 fifo_rd
);

   feed_state_t         state;
   logic                ack;
   logic [20:0]         next_adr;
   logic [20:0]         req_adr;
   logic                wr_req;
   logic                adr_hit;
   logic                push;
   entry_t              push_data;
   logic                fifo_full;
   logic [DEPTH_BITS:0] fifo_count;
   logic                unused_adr;

   assign req_adr    = wbs.wbs_adr_i[22:2];
   assign unused_adr = ^{wbs.wbs_adr_i[31:23], wbs.wbs_adr_i[1:0]};
   assign wr_req     = wbs.wbs_cyc_i && wbs.wbs_stb_i && wbs.wbs_we_i;
   assign adr_hit    = (req_adr == next_adr);
   assign push_data  = make_entry(wbs.wbs_sel_i, wbs.wbs_dat_i);

   // Ack low in the accept cycle gives the master a cycle to move on.
   assign push = (state == FEED_FILL) && wr_req && adr_hit
              && !fifo_full && !ack;

   assign en            = (state == FEED_FILL) || (state == FEED_DRAIN);
   assign wbs.wbs_ack_o = ack;

   sdram_sync_fifo #(
      .DEPTH_BITS (DEPTH_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (push),
      .wr_data (push_data),
      .rd      (fifo_rd),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Burst FSM: open on a write, fill while contiguous, drain, wait for idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FEED_IDLE;
         ack      <= 1'b0;
         address  <= '0;
         next_adr <= '0;
      end else begin
         ack <= push;
         unique case (state)
            FEED_IDLE: begin
               if (wr_req && ready) begin
                  address  <= {req_adr, 1'b0};
                  next_adr <= req_adr;
                  state    <= FEED_FILL;
               end
            end
            FEED_FILL: begin
               if (push) begin
                  next_adr <= next_adr + 1'b1;
               end else if (!wbs.wbs_cyc_i
                         || (wr_req && !adr_hit && !ack)) begin
                  state <= FEED_DRAIN;
               end
            end
            FEED_DRAIN: begin
               if (fifo_count == '0) begin
                  state <= FEED_WAIT;
               end
            end
            FEED_WAIT: begin
               if (ready) begin
                  state <= FEED_IDLE;
               end
            end
            default: begin
               state <= FEED_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_write_feeder.sv
// Bench for sdram_write_feeder with a 4-entry FIFO.
// Popped words are checked against a queue of expected entries.
module tb_sdram_write_feeder;

   localparam int DB = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [21:0] address;
   logic        ready;
   logic [35:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_rd;

   sdram_write_feeder_if wb ();

   sdram_write_feeder #(
      .DEPTH_BITS (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wbs        (wb),
      .en         (en),
      .address    (address),
      .ready      (ready),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          ack_count = 0;
   logic [35:0] exp_q [$];
   logic [35:0] last_exp = '0;
   logic [35:0] mon_e;
   logic        pop_pend = 1'b0;

   function automatic logic [35:0] exp_entry(
      input logic [3:0]  sel,
      input logic [31:0] dat
   );
      return {~sel, dat};
   endfunction

   task automatic check(
      input string       name,
      input logic [35:0] act,
      input logic [35:0] req
   );
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Remember an accepted pop so the next negedge can compare the word.
   always @(posedge clk) begin
      pop_pend <= fifo_rd && !fifo_empty && !rst;
   end

   // Monitor: count acks and score every popped word.
   always @(negedge clk) begin
      if (wb.wbs_ack_o) ack_count++;
      if (pop_pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected actual=%h required=none",
                     fifo_data);
         end else begin
            mon_e = exp_q.pop_front();
            last_exp = mon_e;
            check("fifo_data", fifo_data, mon_e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_start(
      input logic [31:0] adr,
      input logic [3:0]  sel,
      input logic [31:0] dat
   );
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = 1'b1;
      wb.wbs_adr_i = adr;
      wb.wbs_sel_i = sel;
      wb.wbs_dat_i = dat;
   endtask

   task automatic wb_end();
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wb.wbs_ack_o) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (ok) wb.wbs_stb_i = 1'b0;
   endtask

   task automatic pop1();
      fifo_rd = 1'b1;
      step(1);
      fifo_rd = 1'b0;
   endtask

   task automatic wait_en_low(input string name, input int budget);
      for (int i = 0; i < budget && en; i++) step(1);
      check(name, 36'(en), 36'd0);
   endtask

   task automatic reset_outputs(input string tag);
      check({tag, "_ack"}, 36'(wb.wbs_ack_o), 36'd0);
      check({tag, "_en"}, 36'(en), 36'd0);
      check({tag, "_address"}, 36'(address), 36'd0);
      check({tag, "_empty"}, 36'(fifo_empty), 36'd1);
      check({tag, "_data"}, fifo_data, 36'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok;
      int          base;
      logic [31:0] d;
      logic [3:0]  s;

      rst = 1'b1;
      ready = 1'b1;
      fifo_rd = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = 4'h0;
      wb.wbs_adr_i = 32'h0;
      wb.wbs_dat_i = 32'h0;
      step(2);
      reset_outputs("reset");
      rst = 1'b0;
      step(1);

      // single full-word write
      base = ack_count;
      wb_start(32'h100, 4'hF, 32'hDEADBEEF);
      exp_q.push_back(36'h0_DEADBEEF);
      wait_ack(6, ok);
      check("single_ack", 36'(ok), 36'd1);
      check("single_en", 36'(en), 36'd1);
      check("single_address", 36'(address), 36'h080);
      check("single_not_empty", 36'(fifo_empty), 36'd0);
      wb_end();
      pop1();
      wait_en_low("single_en_fall", 6);
      check("single_ack_once", 36'(ack_count - base), 36'd1);

      // partial byte select becomes a mask
      wb_start(32'h200, 4'b0011, 32'h12345678);
      exp_q.push_back(36'hC_12345678);
      wait_ack(8, ok);
      check("mask_ack", 36'(ok), 36'd1);
      wb_end();
      pop1();
      wait_en_low("mask_en_fall", 6);

      // contiguous burst into a 4-entry FIFO
      base = ack_count;
      for (int i = 0; i < 4; i++) begin
         d = 32'hA000_0000 + 32'(i);
         s = 4'(i + 1);
         wb_start(32'(i * 4), s, d);
         exp_q.push_back(exp_entry(s, d));
         wait_ack(8, ok);
         check("burst_ack", 36'(ok), 36'd1);
      end
      wb_start(32'h10, 4'hF, 32'hA000_0004);
      wait_ack(8, ok);
      check("full_stall", 36'(ok), 36'd0);
      check("full_ack_count", 36'(ack_count - base), 36'd4);
      pop1();
      exp_q.push_back(exp_entry(4'hF, 32'hA000_0004));
      wait_ack(8, ok);
      check("after_pop_ack", 36'(ok), 36'd1);
      wb_start(32'h14, 4'hF, 32'hA000_0005);
      wait_ack(8, ok);
      check("refull_stall", 36'(ok), 36'd0);
      check("refull_ack_count", 36'(ack_count - base), 36'd5);
      wb_end();
      for (int i = 0; i < 4; i++) pop1();
      wait_en_low("burst_en_fall", 6);

      // non-contiguous address closes the burst
      wb_start(32'h10, 4'h5, 32'h1111_0010);
      exp_q.push_back(36'hA_1111_0010);
      wait_ack(8, ok);
      check("gap_first_ack", 36'(ok), 36'd1);
      ready = 1'b0;
      base = ack_count;
      wb_start(32'h40, 4'hF, 32'h2222_0040);
      step(6);
      check("gap_no_ack_drain", 36'(ack_count - base), 36'd0);
      check("gap_en_drain", 36'(en), 36'd1);
      pop1();
      step(4);
      check("gap_en_wait", 36'(en), 36'd0);
      check("gap_no_ack_wait", 36'(ack_count - base), 36'd0);
      ready = 1'b1;
      exp_q.push_back(36'h0_2222_0040);
      wait_ack(8, ok);
      check("gap_second_ack", 36'(ok), 36'd1);
      check("gap_address", 36'(address), 36'h020);
      check("gap_en_new", 36'(en), 36'd1);
      wb_end();
      pop1();
      wait_en_low("gap_en_fall", 6);

      // pop while empty is ignored
      step(2);
      fifo_rd = 1'b1;
      step(1);
      fifo_rd = 1'b0;
      step(1);
      check("empty_rd_data", fifo_data, last_exp);
      check("empty_rd_empty", 36'(fifo_empty), 36'd1);
      wb_start(32'h80, 4'h8, 32'h3333_0080);
      exp_q.push_back(36'h7_3333_0080);
      wait_ack(8, ok);
      check("empty_rd_ack", 36'(ok), 36'd1);
      wb_end();
      pop1();
      wait_en_low("empty_rd_en_fall", 6);

      // reset in the middle of a burst
      for (int i = 0; i < 3; i++) begin
         wb_start(32'h300 + 32'(i * 4), 4'hF, 32'hBEEF_0000 + 32'(i));
         wait_ack(8, ok);
         check("rst_fill_ack", 36'(ok), 36'd1);
      end
      rst = 1'b1;
      wb_end();
      step(1);
      reset_outputs("midrst");
      rst = 1'b0;
      step(1);
      wb_start(32'h4, 4'h2, 32'h4444_0004);
      exp_q.push_back(36'hD_4444_0004);
      wait_ack(8, ok);
      check("post_rst_ack", 36'(ok), 36'd1);
      wb_end();
      pop1();
      wait_en_low("post_rst_en_fall", 6);

      step(3);
      check("queue_drained", 36'(exp_q.size()), 36'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_write_feeder.md
# sdram_write_feeder

Wishbone-side write front end for the SDRAM write stage. It accepts 32-bit Wishbone write cycles, converts byte selects to SDRAM data masks, and buffers words in an internal FIFO. It presents the burst start address, enable and FIFO read interface that the `sdram_write` state machine consumes. It also detects non-contiguous addresses and closes the current burst so that `sdram_write` returns to IDLE before a new address is issued.

## Interface

- `DEPTH_BITS`, default 4: FIFO depth is 2^DEPTH_BITS 36-bit entries.
- `clk`  in  1  the single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone cycle, strobe and write-enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address; bits [22:2] are used.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge per accepted word.
- `en`  out  1  write-burst enable to the write stage.
- `address`  out  22  burst start address in 16-bit units: {wbs_adr_i[22:2], 1'b0}.
- `ready`  in  1  write stage idle.
- `fifo_data`  out  36  {mask[3:0], data[31:0]}; mask = ~wbs_sel_i, so mask[3:2] covers data[31:16].
- `fifo_empty`  out  1  FIFO holds no entries.
- `fifo_rd`  in  1  pop request from the write stage.

## Operation

States and transitions:
- IDLE
  - `en` = 0.
  - When `cyc & stb & we` and `ready`: latch `address` from `wbs_adr_i`, set `next_adr` = wbs_adr_i[22:2], go to FILL.
  - A request with `we` = 0 is never acked.
- FILL
  - `en` = 1.
  - Accept a write when `cyc & stb & we`, `wbs_adr_i[22:2] == next_adr`, FIFO not full and `ack` is low this cycle: push, pulse `ack`, and increment `next_adr` modulo 2^21 (wraps to 0).
  - Address mismatch, or `cyc` low: go to DRAIN with no ack.
  - FIFO full: stall, holding `ack` low.
- DRAIN
  - `en` = 1 until `fifo_empty`, then `en` = 0 and go to WAIT.
  - No acks are issued.
- WAIT
  - `en` = 0. When `ready` = 1, go to IDLE.
  - A pending mismatched write then starts a new burst.
- The write stage samples `address` only while `en` = 1 and `fifo_empty` = 0. `address` is stable from FILL entry through WAIT exit.

FIFO rules:
- Push is gated by `full`, computed before any same-cycle pop.
- Simultaneous push and pop leaves the count unchanged.
- `fifo_rd` while empty is ignored and `fifo_data` holds its value.
- Pointers wrap at 2^DEPTH_BITS.
- Count is DEPTH_BITS+1 bits wide: `full` = count == 2^DEPTH_BITS, `empty` = count == 0.

## Timing

- Reset values:
  - `wbs_ack_o` = 0, `en` = 0, `address` = 0.
  - `fifo_empty` = 1, `fifo_data` = 0.
  - FIFO count and pointers = 0, state = IDLE.
- Reset mid-burst discards FIFO contents, with no partial ack.
- Ack latency:
  - First ack is 2 cycles after `stb` rises in IDLE: one cycle to enter FILL, then ack.
  - Sustained rate is one ack every 2 cycles, because `ack` is deasserted between words.
- `fifo_empty` falls the cycle after the first push.
- `fifo_data` is registered: it updates the cycle after `fifo_rd` is sampled high and holds until the next pop.
- `en` falls the cycle after `fifo_empty` is seen high in DRAIN.

## Structure

- Shared package or include:
  - state encodings FEED_IDLE=0, FEED_FILL=1, FEED_DRAIN=2, FEED_WAIT=3;
  - the mask/data field offsets (MASK_HI=35, MASK_LO=32) shared with `sdram_write`.
- One sub-module, `sdram_sync_fifo`: 36-bit wide, parameterised depth, registered read, full/empty/count outputs.
- The feeder FSM, address comparator and mask inversion live in the top level.
- Expected size: about 250 lines total.

## Test plan

- Reset, then a single write of adr 0x100, sel 4'hF, dat 0xDEADBEEF:
  - `ack` pulses once;
  - `address` = 0x080 while `en` = 1;
  - after the pop, `fifo_data` = 0x0DEADBEEF;
  - after the drain, `en` falls.
- sel 4'b0011 on dat 0x12345678 -> `fifo_data` = 36'hC_12345678.
- Eight contiguous writes from adr 0x0 with `fifo_rd` held low and DEPTH_BITS=2:
  - exactly 4 acks, then `ack` stays low;
  - popping one entry allows exactly one more ack.
- Writes to adr 0x10 then 0x40:
  - the second write is not acked until `en` has dropped and `ready` = 1;
  - a new burst then starts with `address` = 0x020.
- `fifo_rd` pulsed while `fifo_empty` = 1 -> `fifo_data` and count are unchanged.
- `rst` asserted during FILL with 3 entries queued -> next cycle all outputs are at reset values and `fifo_empty` = 1.
